// File: rtl/vigna_bus_arbiter_if.sv
// Valid/ready memory bus used by the vigna core ports and the unified memory port.
// Handshake: the master raises valid with addr/wdata/wstrb and holds all of them
// stable until it samples ready=1 on a rising edge. ready is a one-cycle completion
// pulse, and rdata is meaningful in that cycle. wstrb=0 means read.
interface vigna_bus_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       rdata;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;

  // Request side: issues transactions.
  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  // Completion side: answers transactions.
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/vigna_bus_arbiter.sv
// vigna_bus_arbiter: merges the core's instruction port (i_bus) and data port (d_bus)
// onto one memory bus (m_bus). One transaction is outstanding at a time, and
// simultaneous requests are granted round-robin. Returned read data is registered
// per port and held until that port's next completion.
// Optional feature: define VIGNA_ARB_TIMEOUT_EN to enable a watchdog. It aborts a
// transaction after TIMEOUT_CYCLES cycles without m_ready and pulses bus_err.
module vigna_bus_arbiter #(
  parameter int          ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  vigna_bus_arbiter_if.slave      i_bus,
  vigna_bus_arbiter_if.slave      d_bus,
  vigna_bus_arbiter_if.master     m_bus,
  output logic                    bus_err,
  output logic [1:0]              dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // The watchdog counter is 16 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("vigna_bus_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_t              state_q, state_d;
  logic                gnt_d_q, gnt_d_d;    // 1: data port owns the current transaction
  logic                last_d_q, last_d_d;  // 1: the most recent grant went to the data port
  logic                m_valid_q, m_valid_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [31:0]         m_wdata_q, m_wdata_d;
  logic [3:0]          m_wstrb_q, m_wstrb_d;
  logic                i_ready_q, i_ready_d;
  logic                d_ready_q, d_ready_d;
  logic [31:0]         i_rdata_q, i_rdata_d;
  logic [31:0]         d_rdata_q, d_rdata_d;
  logic                bus_err_q, bus_err_d;
  logic                pick_d;

`ifdef VIGNA_ARB_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]         wait_q, wait_d;
`endif

  // Arbitration: the data port wins when it is alone, or on a tie when the
  // instruction port had the last grant.
  assign pick_d = d_bus.valid & (~i_bus.valid | ~last_d_q);

  // Next-state and registered-output logic for the IDLE/BUSY/RESP sequencer.
  always_comb begin
    state_d   = state_q;
    gnt_d_d   = gnt_d_q;
    last_d_d  = last_d_q;
    m_valid_d = m_valid_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = m_wstrb_q;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    bus_err_d = 1'b0;
`ifdef VIGNA_ARB_TIMEOUT_EN
    wait_d    = wait_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (i_bus.valid || d_bus.valid) begin
          gnt_d_d   = pick_d;
          last_d_d  = pick_d;
          m_valid_d = 1'b1;
          m_addr_d  = pick_d ? d_bus.addr  : i_bus.addr;
          m_wdata_d = pick_d ? d_bus.wdata : i_bus.wdata;
          m_wstrb_d = pick_d ? d_bus.wstrb : i_bus.wstrb;
          state_d   = S_BUSY;
`ifdef VIGNA_ARB_TIMEOUT_EN
          wait_d    = 16'd0;
`endif
        end
      end
      S_BUSY: begin
        // m_ready always beats the watchdog when both land in the same cycle.
        if (m_bus.ready) begin
          m_valid_d = 1'b0;
          if (gnt_d_q) begin
            d_rdata_d = m_bus.rdata;
            d_ready_d = 1'b1;
          end else begin
            i_rdata_d = m_bus.rdata;
            i_ready_d = 1'b1;
          end
          state_d = S_RESP;
        end
`ifdef VIGNA_ARB_TIMEOUT_EN
        else if (wait_q == WAIT_LAST) begin
          m_valid_d = 1'b0;
          bus_err_d = 1'b1;
          if (gnt_d_q) begin
            d_rdata_d = 32'h0;
            d_ready_d = 1'b1;
          end else begin
            i_rdata_d = 32'h0;
            i_ready_d = 1'b1;
          end
          state_d = S_RESP;
        end else begin
          wait_d = wait_q + 16'd1;
        end
`endif
      end
      S_RESP: begin
        // ready/bus_err fall back to their zero defaults here.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      gnt_d_q   <= 1'b0;
      last_d_q  <= 1'b1;
      m_valid_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= 32'h0;
      m_wstrb_q <= 4'h0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_rdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_d_q   <= gnt_d_d;
      last_d_q  <= last_d_d;
      m_valid_q <= m_valid_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      bus_err_q <= bus_err_d;
    end
  end

`ifdef VIGNA_ARB_TIMEOUT_EN
  // Watchdog wait counter for the current BUSY period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q <= 16'd0;
    end else begin
      wait_q <= wait_d;
    end
  end
`endif

  assign m_bus.valid = m_valid_q;
  assign m_bus.addr  = m_addr_q;
  assign m_bus.wdata = m_wdata_q;
  assign m_bus.wstrb = m_wstrb_q;
  assign i_bus.ready = i_ready_q;
  assign i_bus.rdata = i_rdata_q;
  assign d_bus.ready = d_ready_q;
  assign d_bus.rdata = d_rdata_q;
  assign bus_err     = bus_err_q;
  assign dbg_state_o = state_q;

endmodule
